uart_tx_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares the single UART transmitter (`txdata`/`wr_en`/`tx_busy`) between two frame requesters, such as the custom-instruction command path and a status/keepalive source. Each granted request is serialized as a checksummed frame: header, 1–4 payload bytes, checksum. The framing matches the checksum rules of the receive-side state machine. The block sits between the requesters and the UART TX core.

---
 rtl/uart_frame_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared framing definitions for the UART command link.
// Contents:
//   state_e         - frame sequencer state encoding (also decoded by the bench/debug port)
//   HdrTag          - default upper nibble of every header byte
//   Hdr* positions  - bit positions of the header fields {tag, src, 0, len}
//   frame_header()  - assembles a header byte from its fields
//   frame_checksum()- two's-complement checksum so a whole frame sums to 0 mod 256
package uart_frame_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StSend   = 3'd2,
    StGuard  = 3'd3,
    StWaitTx = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam logic [3:0] HdrTag = 4'hA;

  // Header layout: [7:4] tag, [3] source, [2] reserved zero, [1:0] payload length minus one.
  localparam int unsigned HdrTagLsb = 4;
  localparam int unsigned HdrSrcBit = 3;
  localparam int unsigned HdrRsvBit = 2;
  localparam int unsigned HdrLenLsb = 0;

  function automatic logic [7:0] frame_header(input logic [3:0] tag,
                                              input logic       src,
                                              input logic [1:0] len);
    logic [7:0] hdr;
    hdr                   = '0;
    hdr[HdrTagLsb +: 4]   = tag;
    hdr[HdrSrcBit]        = src;
    hdr[HdrRsvBit]        = 1'b0;
    hdr[HdrLenLsb +: 2]   = len;
    return hdr;
  endfunction

  // Negated running sum: adding this byte to the accumulator gives 0 mod 256.
  function automatic logic [7:0] frame_checksum(input logic [7:0] acc);
    return (~acc) + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter with a registered last-served pointer.
// Ports:
//   clk_i        - clock
//   reset_i      - synchronous active-high reset; pointer returns to 1 so requester 0 wins first
//   req_i        - request vector
//   update_i     - load the pointer with update_src_i (asserted when a frame completes)
//   update_src_i - index of the requester just served
//   grant_o      - one-hot grant, combinational from req_i and the pointer
module rr_arbiter (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       update_src_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= 1'b1;
    end else if (update_i) begin
      ptr_q <= update_src_i;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      // Contention: favour whoever was not served last.
      grant_o = ptr_q ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two frame requesters. Each granted request is sent as
// header, 1-4 payload bytes (MSB first) and a checksum byte making the frame sum 0 mod 256.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   req0/1             - frame requests, held until the matching done pulse
//   len0/1             - payload length minus one
//   data0/1            - payload, [31:24] sent first
//   done0/1            - one-cycle pulse once the requester's checksum byte has left the TX
//   txdata, wr_en      - byte and write strobe to the UART TX
//   tx_busy            - UART TX busy flag (rises the cycle after wr_en)
//   state              - current sequencer state for debug
module uart_tx_arbiter
  import uart_frame_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter logic [3:0]  HDR_TAG = HdrTag
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  len0,
  input  logic [1:0]  len1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  txdata,
  output logic        wr_en,
  input  logic        tx_busy,
  output logic [2:0]  state
);

  localparam int unsigned SrcW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q;
  logic [SrcW-1:0]   src_q;
  logic [1:0]        len_q;
  logic [31:0]       data_q;
  logic [2:0]        cnt_q;     // index of the byte in txdata_q: 0 header, then payload, then checksum
  logic [7:0]        acc_q;
  logic [7:0]        txdata_q;
  logic [1:0]        done_q;

  logic [1:0]        grant;
  logic [7:0]        payload_byte;
  logic [7:0]        next_byte;
  logic              sending_last;
  logic              next_is_cks;

  rr_arbiter u_rr_arbiter (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        ({req1, req0}),
    .update_i     (state_q == StDone),
    .update_src_i (src_q[0]),
    .grant_o      (grant)
  );

  // The byte following cnt_q is payload index cnt_q, or the checksum once the payload is done.
  assign next_is_cks  = (cnt_q == ({1'b0, len_q} + 3'd1));
  assign sending_last = (cnt_q == ({1'b0, len_q} + 3'd2));

  always_comb begin
    payload_byte = data_q[31:24];
    unique case (cnt_q[1:0])
      2'd0: payload_byte = data_q[31:24];
      2'd1: payload_byte = data_q[23:16];
      2'd2: payload_byte = data_q[15:8];
      2'd3: payload_byte = data_q[7:0];
      default: payload_byte = data_q[31:24];
    endcase
  end

  // acc_q already includes every byte up to cnt_q when this is consumed in WAIT_TX.
  assign next_byte = next_is_cks ? frame_checksum(acc_q) : payload_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      src_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      txdata_q <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            src_q   <= SrcW'(grant[1]);
            state_q <= StLoad;
          end
        end
        StLoad: begin
          len_q    <= src_q[0] ? len1 : len0;
          data_q   <= src_q[0] ? data1 : data0;
          txdata_q <= frame_header(HDR_TAG, src_q[0], src_q[0] ? len1 : len0);
          cnt_q    <= '0;
          acc_q    <= '0;
          state_q  <= StSend;
        end
        StSend: begin
          if (!tx_busy) begin
            acc_q   <= acc_q + txdata_q;
            state_q <= StGuard;
          end
        end
        StGuard: begin
          // The UART raises busy one cycle after the strobe; do not trust it yet.
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (!tx_busy) begin
            if (sending_last) begin
              done_q[src_q[0]] <= 1'b1;
              state_q          <= StDone;
            end else begin
              cnt_q    <= cnt_q + 3'd1;
              txdata_q <= next_byte;
              state_q  <= StSend;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The strobe must land in the SEND cycle that sees the TX idle, so it is decoded from the
  // registered state and the live busy flag rather than registered itself.
  assign wr_en  = (state_q == StSend) && !tx_busy;
  assign txdata = txdata_q;
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign state  = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_v = 2'b00;
  logic [1:0]  len_v [2];
  logic [31:0] data_v [2];
  logic        done0, done1, wr_en, tx_busy;
  logic [7:0]  txdata;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // UART TX model
  int   busy_cnt = 0;
  int   busy_dur = 3;
  logic rand_busy = 1'b0;
  logic force_busy = 1'b0;

  // Requester driver controls
  logic rand_req = 1'b0;
  int   keep_v [2];
  logic [1:0] done_s = 2'b00;

  // Observed bytes and model state
  logic [7:0] log_q [$];
  logic [7:0] exp_b [$];
  logic       chk_en = 1'b0;
  logic       prev_wr = 1'b0;
  int         cyc = 0;
  logic       m_in_frame = 1'b0;
  logic       m_wait_idle = 1'b0;
  logic       m_src = 1'b0;
  logic       m_last = 1'b1;
  int         m_due = 0;
  int         m_strobe_cyc = 0;
  int         m_sum = 0;
  int         m_frames = 0;
  logic [7:0] m_q [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ    (2),
    .HDR_TAG (4'hA)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req_v[0]),
    .req1    (req_v[1]),
    .len0    (len_v[0]),
    .len1    (len_v[1]),
    .data0   (data_v[0]),
    .data1   (data_v[1]),
    .done0   (done0),
    .done1   (done1),
    .txdata  (txdata),
    .wr_en   (wr_en),
    .tx_busy (tx_busy),
    .state   (state)
  );

  always @(posedge clk) begin
    if (wr_en) busy_cnt <= rand_busy ? int'($urandom_range(1, 4)) : busy_dur;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: builds the byte list of a frame from plain arithmetic.
  task automatic model_start(input logic src);
    int ln, s, b, hdr;
    logic [31:0] d;
    ln = int'(len_v[src]);
    d  = data_v[src];
    m_q.delete();
    hdr = 160 + (src ? 8 : 0) + ln;
    m_q.push_back(8'(hdr));
    s = hdr;
    for (int k = 0; k <= ln; k++) begin
      b = int'((d >> (24 - 8 * k)) & 32'hFF);
      m_q.push_back(8'(b));
      s += b;
    end
    m_q.push_back(8'((256 - (s % 256)) % 256));
    m_src = src;
    m_in_frame = 1'b1;
    m_wait_idle = 1'b0;
    m_due = cyc + 2;
    m_sum = 0;
  endtask

  always @(negedge clk) begin
    logic e_wr, e_done;
    cyc++;
    done_s = {done1, done0};
    if (wr_en) log_q.push_back(txdata);
    if (chk_en) begin
      e_wr = 1'b0;
      e_done = 1'b0;
      if (m_in_frame) begin
        if (m_wait_idle) begin
          if (cyc >= m_strobe_cyc + 2 && !tx_busy) begin
            m_wait_idle = 1'b0;
            m_due = cyc + 1;
          end
        end else if (cyc >= m_due) begin
          if (m_q.size() != 0) e_wr = !tx_busy;
          else e_done = 1'b1;
        end
      end
      chk("wr_en", wr_en, e_wr);
      chk("done", {done1, done0}, e_done ? (m_src ? 2'b10 : 2'b01) : 2'b00);
      if (wr_en) begin
        chk("wr_while_busy", tx_busy, 1'b0);
        chk("wr_back_to_back", prev_wr, 1'b0);
        m_sum += int'(txdata);
      end
      if (e_wr) begin
        chk("txdata", txdata, m_q[0]);
        void'(m_q.pop_front());
        m_strobe_cyc = cyc;
        m_wait_idle = 1'b1;
      end
      if (e_done) begin
        chk("frame_sum", m_sum % 256, 0);
        m_in_frame = 1'b0;
        m_last = m_src;
        m_frames++;
      end
      if (reset) begin
        m_in_frame = 1'b0;
        m_last = 1'b1;
        m_q.delete();
      end else if (!m_in_frame && !e_done && req_v != 2'b00) begin
        model_start((req_v == 2'b11) ? !m_last : req_v[1]);
      end
    end
    prev_wr = wr_en;
  end

  // One cycle of requester behaviour: drop a request on its done, optionally raise new ones.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (req_v[i] && done_s[i]) begin
        if (keep_v[i] > 0) keep_v[i]--;
        else req_v[i] = 1'b0;
      end else if (!req_v[i] && rand_req && $urandom_range(0, 3) == 0) begin
        len_v[i]  = 2'($urandom_range(0, 3));
        data_v[i] = $urandom;
        req_v[i]  = 1'b1;
      end
    end
  endtask

  task automatic wait_quiet(input string name, input int bound);
    int n;
    n = 0;
    while ((req_v != 2'b00 || m_in_frame) && n < bound) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, (req_v != 2'b00 || m_in_frame), 1'b0);
  endtask

  task automatic chk_frame(input string name, input int start);
    chk({name, "_len"}, log_q.size() - start, exp_b.size());
    if (log_q.size() - start == exp_b.size())
      for (int i = 0; i < exp_b.size(); i++) chk(name, log_q[start + i], exp_b[i]);
  endtask

  initial begin
    int st, n;
    keep_v[0] = 0; keep_v[1] = 0;
    len_v[0] = '0; len_v[1] = '0;
    data_v[0] = '0; data_v[1] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_txdata", txdata, 8'h00);
    chk("rst_done", {done1, done0}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Simultaneous requests: src0 first, then src1 because req0 is still held, then src0 again
    step();
    st = log_q.size();
    len_v[0] = 2'd0; data_v[0] = 32'h5500_0000;
    len_v[1] = 2'd0; data_v[1] = 32'h3300_0000;
    keep_v[0] = 1;
    req_v = 2'b11;
    wait_quiet("simul", 300);
    exp_b = {8'hA0, 8'h55, 8'h0B, 8'hA8, 8'h33, 8'h25, 8'hA0, 8'h55, 8'h0B};
    chk_frame("simul", st);

    // Single frame
    step();
    st = log_q.size();
    len_v[0] = 2'd1; data_v[0] = 32'h6162_0000; req_v[0] = 1'b1;
    wait_quiet("single", 200);
    exp_b = {8'hA1, 8'h61, 8'h62, 8'h9C};
    chk_frame("single", st);

    // Full length
    step();
    st = log_q.size();
    len_v[1] = 2'd3; data_v[1] = 32'h0102_0304; req_v[1] = 1'b1;
    wait_quiet("full", 200);
    exp_b = {8'hAB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h4B};
    chk_frame("full", st);

    // Busy hold-off at the first SEND
    step();
    st = log_q.size();
    len_v[0] = 2'd0; data_v[0] = 32'hC300_0000; req_v[0] = 1'b1;
    step();
    force_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      chk("holdoff_state", state, 3'd2);
      chk("holdoff_wr_en", wr_en, 1'b0);
    end
    step();
    force_busy = 1'b0;
    @(negedge clk);
    chk("holdoff_release_wr", wr_en, 1'b1);
    chk("holdoff_release_byte", txdata, 8'hA0);
    wait_quiet("holdoff", 200);
    exp_b = {8'hA0, 8'hC3, 8'h9D};
    chk_frame("holdoff", st);

    // Reset in the WAIT_TX of the third byte
    step();
    st = log_q.size();
    len_v[1] = 2'd3; data_v[1] = 32'h0102_0304; req_v[1] = 1'b1;
    n = 0;
    while (log_q.size() < st + 3 && n < 100) begin
      step();
      n++;
    end
    chk("midrst_reach_timeout", log_q.size() >= st + 3, 1'b1);
    step();
    reset = 1'b1;
    req_v[1] = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_state", state, 3'd0);
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_done", {done1, done0}, 2'b00);
    for (int k = 0; k < 10; k++) step();
    chk("midrst_no_more_bytes", log_q.size() - st, 3);
    st = log_q.size();
    req_v[1] = 1'b1;
    wait_quiet("midrst_fresh", 200);
    exp_b = {8'hAB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h4B};
    chk_frame("midrst_fresh", st);

    // Random traffic: 200 frames with random busy lengths
    rand_busy = 1'b1;
    rand_req = 1'b1;
    st = m_frames;
    n = 0;
    while (m_frames < st + 200 && n < 40000) begin
      step();
      n++;
    end
    chk("random_frames_timeout", m_frames >= st + 200, 1'b1);
    rand_req = 1'b0;
    wait_quiet("random_drain", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
